// File: rtl/zap_shift_arbiter_if.sv
// Request, shared-shifter and response signals of zap_shift_arbiter.
// The slave modport is the arbiter's view. The master modport is the requesters/shifter/consumer side.
interface zap_shift_arbiter_if #(
    parameter int unsigned TW = 3
) ();
    logic          i_req0_valid;
    logic          o_req0_ready;
    logic [31:0]   i_req0_source;
    logic [7:0]    i_req0_amount;
    logic          i_req0_carry;
    logic [TW-1:0] i_req0_type;

    logic          i_req1_valid;
    logic          o_req1_ready;
    logic [31:0]   i_req1_source;
    logic [7:0]    i_req1_amount;
    logic          i_req1_carry;
    logic [TW-1:0] i_req1_type;

    logic [31:0]   o_sh_source;
    logic [7:0]    o_sh_amount;
    logic          o_sh_carry;
    logic [TW-1:0] o_sh_type;
    logic [31:0]   i_sh_result;
    logic          i_sh_carry;
    logic          i_sh_sat;

    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic          o_rsp_id;
    logic [31:0]   o_rsp_result;
    logic          o_rsp_carry;
    logic          o_rsp_sat;

    logic          o_sat_sticky;
    logic          i_sat_clear;

    modport slave (
        input  i_req0_valid, i_req0_source, i_req0_amount, i_req0_carry, i_req0_type,
        input  i_req1_valid, i_req1_source, i_req1_amount, i_req1_carry, i_req1_type,
        output o_req0_ready, o_req1_ready,
        output o_sh_source, o_sh_amount, o_sh_carry, o_sh_type,
        input  i_sh_result, i_sh_carry, i_sh_sat,
        output o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_carry, o_rsp_sat,
        input  i_rsp_ready,
        output o_sat_sticky,
        input  i_sat_clear
    );

    modport master (
        output i_req0_valid, i_req0_source, i_req0_amount, i_req0_carry, i_req0_type,
        output i_req1_valid, i_req1_source, i_req1_amount, i_req1_carry, i_req1_type,
        input  o_req0_ready, o_req1_ready,
        input  o_sh_source, o_sh_amount, o_sh_carry, o_sh_type,
        output i_sh_result, i_sh_carry, i_sh_sat,
        input  o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_carry, o_rsp_sat,
        output i_rsp_ready,
        input  o_sat_sticky,
        output i_sat_clear
    );
endinterface

// File: rtl/zap_shift_arbiter.sv
// Round-robin share of one combinational barrel shifter between two requesters.
// Results are returned through a 2-deep in-order response FIFO, and a sticky saturation flag is kept.
module zap_shift_arbiter #(
    parameter int unsigned SHIFT_OPS = 32'd5
) (
    input logic               i_clk,
    input logic               i_reset,
    zap_shift_arbiter_if.slave bus
);
    localparam int unsigned TW = (SHIFT_OPS > 1) ? $clog2(SHIFT_OPS) : 1;
    localparam int unsigned EW = 35;  // {id, result[31:0], carry, sat}

    logic [EW-1:0] mem_q [2];
    logic          rd_ptr_q;
    logic          wr_ptr_q;
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    logic          last_q;
    logic          sticky_q;
    logic          sticky_d;

    logic          rsp_valid;
    logic          pop;
    logic          space;
    logic          any_valid;
    logic          sel;
    logic          push;
    logic [31:0]   sh_source;
    logic [7:0]    sh_amount;
    logic          sh_carry;
    logic [TW-1:0] sh_type;
    logic [EW-1:0] head;

    always_comb begin
        rsp_valid = (count_q != 2'd0);
        pop       = rsp_valid & bus.i_rsp_ready;
        space     = (count_q != 2'd2) | pop;
        any_valid = bus.i_req0_valid | bus.i_req1_valid;
        // Alternate only under contention; otherwise the lone requester wins.
        sel       = (bus.i_req0_valid & bus.i_req1_valid) ? ~last_q : bus.i_req1_valid;
        push      = space & any_valid;

        sh_source = '0;
        sh_amount = '0;
        sh_carry  = 1'b0;
        sh_type   = '0;
        if (any_valid) begin
            if (sel) begin
                sh_source = bus.i_req1_source;
                sh_amount = bus.i_req1_amount;
                sh_carry  = bus.i_req1_carry;
                sh_type   = bus.i_req1_type;
            end else begin
                sh_source = bus.i_req0_source;
                sh_amount = bus.i_req0_amount;
                sh_carry  = bus.i_req0_carry;
                sh_type   = bus.i_req0_type;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // A saturating push in the same cycle as a clear keeps the flag set.
        sticky_d = (bus.i_sat_clear ? 1'b0 : sticky_q) | (push & bus.i_sh_sat);
        head     = mem_q[rd_ptr_q];
    end

    assign bus.o_req0_ready = space & bus.i_req0_valid & ~sel;
    assign bus.o_req1_ready = space & bus.i_req1_valid & sel;
    assign bus.o_sh_source  = sh_source;
    assign bus.o_sh_amount  = sh_amount;
    assign bus.o_sh_carry   = sh_carry;
    assign bus.o_sh_type    = sh_type;
    assign bus.o_rsp_valid  = rsp_valid;
    assign bus.o_rsp_id     = head[34];
    assign bus.o_rsp_result = head[33:2];
    assign bus.o_rsp_carry  = head[1];
    assign bus.o_rsp_sat    = head[0];
    assign bus.o_sat_sticky = sticky_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            last_q   <= 1'b1;
            sticky_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {sel, bus.i_sh_result, bus.i_sh_carry, bus.i_sh_sat};
                wr_ptr_q        <= ~wr_ptr_q;
                last_q          <= sel;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end
endmodule

// File: tb/tb_zap_shift_arbiter.sv
// Directed bench for zap_shift_arbiter: a grant observer queues the hand-computed response of
// each accepted request, and a response monitor pops and compares on every FIFO pop.
module tb_zap_shift_arbiter;
    localparam int unsigned TW = 3;
    localparam logic [TW-1:0] TyLsl = 3'd0;
    localparam logic [TW-1:0] TyLsr = 3'd1;
    localparam logic [TW-1:0] TySat = 3'd4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    zap_shift_arbiter_if #(.TW(TW)) bus ();

    zap_shift_arbiter #(.SHIFT_OPS(5)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    logic [34:0]   exp0;
    logic [34:0]   exp1;
    logic [34:0]   exp_q[$];
    logic [31:0]   src;

    // Reference shifter, combinational from the shared shifter drive.
    logic [63:0]   sat_wide;
    int unsigned   amt;
    always_comb begin
        amt             = int'(bus.o_sh_amount);
        sat_wide        = '0;
        bus.i_sh_result = bus.o_sh_source;
        bus.i_sh_carry  = bus.o_sh_carry;
        bus.i_sh_sat    = 1'b0;
        if (bus.o_sh_type == TyLsl || bus.o_sh_type == TySat) begin
            if (amt != 0) begin
                bus.i_sh_carry  = (amt <= 32) ? bus.o_sh_source[32 - amt] : 1'b0;
                bus.i_sh_result = (amt >= 32) ? 32'd0 : (bus.o_sh_source << amt);
            end
        end else if (bus.o_sh_type == TyLsr) begin
            if (amt != 0) begin
                bus.i_sh_carry  = (amt <= 32) ? bus.o_sh_source[amt - 1] : 1'b0;
                bus.i_sh_result = (amt >= 32) ? 32'd0 : (bus.o_sh_source >> amt);
            end
        end
        if (bus.o_sh_type == TySat) begin
            if (amt >= 32) begin
                bus.i_sh_sat = (bus.o_sh_source != 32'd0);
            end else begin
                sat_wide     = {{32{bus.o_sh_source[31]}}, bus.o_sh_source} << amt;
                bus.i_sh_sat = (sat_wide[63:31] != {33{sat_wide[31]}});
            end
            if (bus.i_sh_sat) begin
                bus.i_sh_result = bus.o_sh_source[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic logic [34:0] ent(input logic id, input logic [31:0] r, input logic c,
                                        input logic s);
        return {id, r, c, s};
    endfunction

    // Grant observer and response monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_req0_ready) exp_q.push_back(exp0);
            if (bus.o_req1_ready) exp_q.push_back(exp1);
            if (bus.o_rsp_valid && bus.i_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(bus.o_rsp_result), 64'hDEAD_0000_0000);
                end else begin
                    check("rsp_entry",
                          64'({bus.o_rsp_id, bus.o_rsp_result, bus.o_rsp_carry, bus.o_rsp_sat}),
                          64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req0_valid  = 1'b0;
        bus.i_req0_source = '0;
        bus.i_req0_amount = '0;
        bus.i_req0_carry  = 1'b0;
        bus.i_req0_type   = '0;
        bus.i_req1_valid  = 1'b0;
        bus.i_req1_source = '0;
        bus.i_req1_amount = '0;
        bus.i_req1_carry  = 1'b0;
        bus.i_req1_type   = '0;
        bus.i_rsp_ready   = 1'b0;
        bus.i_sat_clear   = 1'b0;
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] s,
                           input logic [7:0] a, input logic [TW-1:0] ty);
        if (n == 0) begin
            bus.i_req0_valid  = v;
            bus.i_req0_source = s;
            bus.i_req0_amount = a;
            bus.i_req0_type   = ty;
        end else begin
            bus.i_req1_valid  = v;
            bus.i_req1_source = s;
            bus.i_req1_amount = a;
            bus.i_req1_type   = ty;
        end
    endtask

    task automatic req0_plain(input logic [31:0] s);
        set_req(0, 1'b1, s, 8'd0, TyLsl);
        exp0 = ent(1'b0, s, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        clear_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        check("reset_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        check("reset_sticky", 64'(bus.o_sat_sticky), 64'd0);
        check("reset_rsp_fields",
              64'({bus.o_rsp_id, bus.o_rsp_result, bus.o_rsp_carry, bus.o_rsp_sat}), 64'd0);
        check("reset_ready0_idle", 64'(bus.o_req0_ready), 64'd0);
        next_cycle();
        rst = 1'b0;

        // Single op: 1 << 4.
        bus.i_rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'h1, 8'd4, TyLsl);
        exp0 = ent(1'b0, 32'h10, 1'b0, 1'b0);
        @(negedge clk);
        check("single_ready0", 64'(bus.o_req0_ready), 64'd1);
        check("single_ready1", 64'(bus.o_req1_ready), 64'd0);
        check("single_no_bypass", 64'(bus.o_rsp_valid), 64'd0);
        check("single_sh_amount", 64'(bus.o_sh_amount), 64'd4);
        next_cycle();
        set_req(0, 1'b0, 32'h0, 8'd0, TyLsl);
        @(negedge clk);
        check("single_rsp_valid", 64'(bus.o_rsp_valid), 64'd1);
        check("single_rsp_id", 64'(bus.o_rsp_id), 64'd0);
        check("single_rsp_result", 64'(bus.o_rsp_result), 64'h10);
        check("idle_sh_gated", 64'({bus.o_sh_source, bus.o_sh_amount, bus.o_sh_type}), 64'd0);
        next_cycle();

        // Fairness under continuous dual requests.
        do_reset();
        bus.i_rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'hA, 8'd0, TyLsl);
        set_req(1, 1'b1, 32'hB, 8'd0, TyLsl);
        exp0 = ent(1'b0, 32'hA, 1'b0, 1'b0);
        exp1 = ent(1'b1, 32'hB, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fair_grant0", 64'(bus.o_req0_ready), 64'(i % 2 == 0));
            check("fair_grant1", 64'(bus.o_req1_ready), 64'(i % 2 == 1));
            next_cycle();
        end
        set_req(0, 1'b0, 32'h0, 8'd0, TyLsl);
        set_req(1, 1'b0, 32'h0, 8'd0, TyLsl);
        next_cycle();
        next_cycle();

        // Backpressure: two accepts fill the FIFO, then readies drop.
        bus.i_rsp_ready = 1'b0;
        src = 32'h100;
        req0_plain(src);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_grant0", 64'(bus.o_req0_ready), 64'(i < 2));
            check("bp_grant1", 64'(bus.o_req1_ready), 64'd0);
            next_cycle();
            if (i < 2) begin
                src = src + 32'd1;
                req0_plain(src);
            end
        end
        // Consumer ready: one accept and one pop per cycle with the FIFO held full.
        bus.i_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wrap_grant0", 64'(bus.o_req0_ready), 64'd1);
            check("wrap_rsp_valid", 64'(bus.o_rsp_valid), 64'd1);
            next_cycle();
            check("wrap_count", 64'(dut.count_q), 64'd2);
            src = src + 32'd1;
            req0_plain(src);
        end
        set_req(0, 1'b0, 32'h0, 8'd0, TyLsl);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("drain_empty", 64'(bus.o_rsp_valid), 64'd0);
        next_cycle();

        // Saturation and the sticky flag.
        set_req(1, 1'b1, 32'h4000_0000, 8'd1, TySat);
        exp1 = ent(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        @(negedge clk);
        check("sat_ready1", 64'(bus.o_req1_ready), 64'd1);
        check("sat_sticky_before", 64'(bus.o_sat_sticky), 64'd0);
        next_cycle();
        set_req(1, 1'b0, 32'h0, 8'd0, TyLsl);
        @(negedge clk);
        check("sat_sticky_set", 64'(bus.o_sat_sticky), 64'd1);
        check("sat_rsp_sat", 64'(bus.o_rsp_sat), 64'd1);
        check("sat_rsp_result", 64'(bus.o_rsp_result), 64'h7FFF_FFFF);
        next_cycle();
        bus.i_sat_clear = 1'b1;
        @(negedge clk);
        check("sat_clear_pending", 64'(bus.o_sat_sticky), 64'd1);
        next_cycle();
        bus.i_sat_clear = 1'b0;
        @(negedge clk);
        check("sat_cleared", 64'(bus.o_sat_sticky), 64'd0);
        next_cycle();
        bus.i_sat_clear = 1'b1;
        set_req(1, 1'b1, 32'h4000_0000, 8'd1, TySat);
        @(negedge clk);
        check("sat_clear_push_ready", 64'(bus.o_req1_ready), 64'd1);
        next_cycle();
        bus.i_sat_clear = 1'b0;
        set_req(1, 1'b0, 32'h0, 8'd0, TyLsl);
        @(negedge clk);
        check("sat_set_wins_clear", 64'(bus.o_sat_sticky), 64'd1);
        next_cycle();
        next_cycle();

        // Reset mid-operation with a full FIFO.
        bus.i_rsp_ready = 1'b0;
        set_req(0, 1'b1, 32'h4000_0000, 8'd1, TySat);
        exp0 = ent(1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        @(negedge clk);
        check("mid_grant_a", 64'(bus.o_req0_ready), 64'd1);
        next_cycle();
        req0_plain(32'h200);
        @(negedge clk);
        check("mid_grant_b", 64'(bus.o_req0_ready), 64'd1);
        next_cycle();
        set_req(0, 1'b0, 32'h0, 8'd0, TyLsl);
        @(negedge clk);
        check("mid_full_valid", 64'(bus.o_rsp_valid), 64'd1);
        check("mid_full_sticky", 64'(bus.o_sat_sticky), 64'd1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_reset_valid", 64'(bus.o_rsp_valid), 64'd0);
        check("mid_reset_sticky", 64'(bus.o_sat_sticky), 64'd0);
        check("mid_reset_result", 64'(bus.o_rsp_result), 64'd0);
        #1;
        rst = 1'b0;
        next_cycle();
        bus.i_rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'hC, 8'd0, TyLsl);
        set_req(1, 1'b1, 32'hD, 8'd0, TyLsl);
        exp0 = ent(1'b0, 32'hC, 1'b0, 1'b0);
        exp1 = ent(1'b1, 32'hD, 1'b0, 1'b0);
        @(negedge clk);
        check("post_reset_grant0", 64'(bus.o_req0_ready), 64'd1);
        check("post_reset_grant1", 64'(bus.o_req1_ready), 64'd0);
        next_cycle();
        @(negedge clk);
        check("post_reset_alt1", 64'(bus.o_req1_ready), 64'd1);
        next_cycle();
        set_req(0, 1'b0, 32'h0, 8'd0, TyLsl);
        set_req(1, 1'b0, 32'h0, 8'd0, TyLsl);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
